accnet_tx_framer: RTL and testbench
===================================

// Module: accnet_tx_framer
// PURPOSE
// - Builds Ethernet frames for the tx_* AXI-Stream sink of the QSFP/CMAC core, on the core-side clk.
// - Inputs: one length descriptor per frame and a packed little-endian 64-bit payload word stream.
// - Output: beats with correct tkeep/tlast; short frames zero-padded to MIN_FRAME_BYTES.
// - Illegal-length frames are dropped; payload words flagged as errored cause the frame to be marked bad via tuser.
// PARAMETERS
// DATA_WIDTH       64     payload/stream width in bits; must be 64
// KEEP_WIDTH       8      DATA_WIDTH/8
// LEN_WIDTH        16     descriptor length width (bytes)
// MIN_FRAME_BYTES  60     minimum emitted length before CMAC FCS append
// MAX_FRAME_BYTES  9600   largest legal descriptor length
// CNT_WIDTH        32     statistics counter width
// PORTS
// clk              in   1           core clock; all logic rising-edge
// rst_n            in   1           asynchronous, active-low reset
// desc_valid       in   1           frame descriptor valid
// desc_len         in   LEN_WIDTH   frame payload length in bytes
// desc_ready       out  1           descriptor accepted when valid&ready
// in_valid         in   1           payload word valid
// in_data          in   DATA_WIDTH  payload word; byte 0 in bits [7:0]
// in_err           in   1           word corrupted upstream (e.g. DMA error)
// in_ready         out  1           payload word accepted when valid&ready
// tx_valid         out  1           to core tx_valid
// tx_data          out  DATA_WIDTH  to core tx_data
// tx_keep          out  KEEP_WIDTH  to core tx_keep
// tx_last          out  1           to core tx_last
// tx_user          out  1           to core tx_user; 1 on the last beat means bad frame
// tx_ready         in   1           from core tx_ready
// frames_sent      out  CNT_WIDTH   count of frames whose last beat was accepted; wraps
// frames_dropped   out  CNT_WIDTH   count of frames rejected for illegal length; wraps
// BEHAVIOUR
// - Reset: FSM=IDLE. All outputs are 0: desc_ready, in_ready, tx_*, counters, skid contents.
//   - Reset mid-frame abandons the frame with no tlast. The core TX FIFO is reset in the same domain.
// - FSM states:
//   - IDLE: desc_ready=1. On accept, latch L=desc_len and O=max(L,MIN_FRAME_BYTES).
//     - L==0 or L>MAX_FRAME_BYTES goes to DROP.
//     - Otherwise goes to DATA, with words_rem=ceil(L/8) and bytes_rem=O.
//   - DATA: in_ready = skid can accept.
//     - Each accepted word is emitted as one beat; bytes at index >= L are zeroed.
//     - bad |= in_err.
//     - On the final input word: if O>L and pad beats remain, go to PAD; else the beat is last, go to IDLE.
//   - PAD: emit all-zero beats (in_ready=0) until bytes_rem is exhausted, then go to IDLE.
//   - DROP: in_ready=1, tx untouched. Consume and discard ceil(L/8) words (0 words if L==0).
//     - Then frames_dropped+=1 and go to IDLE.
// - tx_keep:
//   - Non-last beats: 8'hFF.
//   - Last beat: r = bytes_rem (1..8); keep = (r==8) ? 8'hFF : (8'h1<<r)-1.
//   - Example: O=60 gives a last keep of 8'h0F.
// - tx_user: 0 on non-last beats; on the last beat equals bad (bad is cleared in IDLE).
// - Handshake: AXI-Stream rules on the tx side.
//   - tx_data, tx_keep, tx_last and tx_user are stable while tx_valid=1 and tx_ready=0.
//   - tx_valid never drops without a transfer.
// - Latency: a word accepted at cycle n is presented on tx_* at n+1.
//   - Full throughput (1 beat/cycle) while tx_ready=1.
// - Back-to-back frames: desc_ready is asserted only in IDLE, so one bubble cycle between frames is permitted.
// - Backpressure: tx_ready=0 for any duration stalls the FSM. No beat is lost or duplicated.
// - Simultaneous in_valid in IDLE: ignored (in_ready=0).
// - frames_sent increments on acceptance of a tx_last beat, including bad (tx_user=1) frames.
// - Counters wrap modulo 2^CNT_WIDTH.
// STRUCTURE
// - Package accnet_tx_pkg:
//   - state enum {IDLE, DATA, PAD, DROP}
//   - MIN/MAX frame constants
//   - function keep_from_count(r)
//   - function ceil_words(len)
// - Sub-module accnet_axis_skid: 2-entry register slice.
//   - Registers tx_data/keep/last/user.
//   - Provides the registered ready used for in_ready and the PAD advance.
// - Top level holds the FSM, byte/word counters, byte masking and statistics.
// TESTING
// 1. L=128, tx_ready=1: 16 beats, keep FF; beat 15 has last=1, keep=FF, user=0; frames_sent=1.
// 2. L=13: beat0 keep FF; beat1 bytes 5..7 zeroed; beats 2..6 zero; beat7 keep 0F, last=1.
// 3. L=61: 8 beats; beat7 keep 8'h1F; no pad beats.
// 4. L=0 then L=9601 with 1201 words: no tx beats, all words consumed, frames_dropped=2.
//    - Next L=64 frame emits normally.
// 5. L=64, in_err on word 3, random tx_ready (50%): 8 beats in order, only beat7 user=1.
//    - Data and sideband stable while stalled.
// 6. rst_n asserted mid-PAD of an L=20 frame: outputs 0 immediately.
//    - After release, an L=64 frame is emitted cleanly and frames_sent=1.

Source files
------------

// File: rtl/accnet_tx_pkg.sv
// accnet_tx_pkg: shared constants, FSM state type and helpers for the
// accnet TX framer.
//   keep_from_count(r) : tkeep for a final beat carrying r valid bytes (1..8)
//   ceil_words(len)    : number of 64-bit payload words covering len bytes
package accnet_tx_pkg;

  localparam int DATA_W          = 64;
  localparam int KEEP_W          = 8;
  localparam int LEN_W           = 16;
  localparam int CNT_W           = 32;
  localparam int MIN_FRAME_BYTES = 60;
  localparam int MAX_FRAME_BYTES = 9600;

  typedef enum logic [1:0] {IDLE, DATA, PAD, DROP} state_t;

  function automatic logic [KEEP_W-1:0] keep_from_count(input logic [3:0] r);
    if (r >= 4'd8) return {KEEP_W{1'b1}};
    return (KEEP_W'(1) << r) - KEEP_W'(1);
  endfunction

  function automatic logic [LEN_W-1:0] ceil_words(input logic [LEN_W-1:0] len);
    return (len >> 3) + LEN_W'(|len[2:0]);
  endfunction

endpackage

// File: rtl/accnet_axis_skid.sv
// accnet_axis_skid: 2-entry AXI-Stream register slice.
//   s_valid/s_data/s_ready : upstream side; s_ready is registered (skid empty)
//   m_valid/m_data/m_ready : downstream side, fully registered
// A beat accepted at cycle n appears on m_* at n+1; full throughput when
// m_ready stays high. The skid entry absorbs the one beat in flight when
// the downstream stalls, so s_ready never depends combinationally on m_ready.
module accnet_axis_skid #(
  parameter int W = 74
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         s_valid,
  input  logic [W-1:0] s_data,
  output logic         s_ready,
  output logic         m_valid,
  output logic [W-1:0] m_data,
  input  logic         m_ready
);

  logic [W-1:0] skid_data;
  logic         skid_valid;

  assign s_ready = !skid_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid    <= 1'b0;
      m_data     <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (!skid_valid) begin
      if (!m_valid || m_ready) begin
        m_valid <= s_valid;
        if (s_valid) m_data <= s_data;
      end else if (s_valid) begin
        skid_valid <= 1'b1;
        skid_data  <= s_data;
      end
    end else if (m_ready) begin
      // output register holds a valid beat whenever the skid is full
      m_data     <= skid_data;
      skid_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/accnet_tx_framer.sv
// accnet_tx_framer: builds Ethernet frames for the CMAC tx AXI-Stream sink.
//   desc_valid/desc_len/desc_ready : one length descriptor per frame
//   in_valid/in_data/in_err/in_ready : little-endian 64-bit payload words
//   tx_valid/tx_data/tx_keep/tx_last/tx_user/tx_ready : core tx stream;
//     tx_user=1 on the last beat marks a bad frame
//   frames_sent / frames_dropped : wrapping statistics counters
// Short frames are zero-padded to MIN_FRAME_BYTES; illegal lengths are
// consumed from the payload stream and discarded.
//
// state | meaning
// IDLE  | waiting for a descriptor; bad flag cleared
// DATA  | forwarding payload words, masking bytes past the frame length
// PAD   | emitting all-zero beats up to the minimum frame length
// DROP  | swallowing payload words of an illegal-length frame
module accnet_tx_framer
  import accnet_tx_pkg::*;
#(
  parameter int DATA_WIDTH      = DATA_W,
  parameter int KEEP_WIDTH      = KEEP_W,
  parameter int LEN_WIDTH       = LEN_W,
  parameter int MIN_FRAME_BYTES = accnet_tx_pkg::MIN_FRAME_BYTES,
  parameter int MAX_FRAME_BYTES = accnet_tx_pkg::MAX_FRAME_BYTES,
  parameter int CNT_WIDTH       = CNT_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  desc_valid,
  input  logic [LEN_WIDTH-1:0]  desc_len,
  output logic                  desc_ready,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_err,
  output logic                  in_ready,
  output logic                  tx_valid,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic [KEEP_WIDTH-1:0] tx_keep,
  output logic                  tx_last,
  output logic                  tx_user,
  input  logic                  tx_ready,
  output logic [CNT_WIDTH-1:0]  frames_sent,
  output logic [CNT_WIDTH-1:0]  frames_dropped
);

  localparam int BW = DATA_WIDTH + KEEP_WIDTH + 2;
  localparam logic [LEN_WIDTH-1:0] MIN_LEN = LEN_WIDTH'(MIN_FRAME_BYTES);
  localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(MAX_FRAME_BYTES);
  localparam logic [LEN_WIDTH-1:0] BEAT_BYTES = LEN_WIDTH'(8);

  state_t                state, state_nxt;
  logic                  armed;
  logic [2:0]            len_tail;
  logic [LEN_WIDTH-1:0]  words_rem;
  logic [LEN_WIDTH-1:0]  bytes_rem;
  logic                  bad;

  logic                  push_valid;
  logic [DATA_WIDTH-1:0] push_data;
  logic [KEEP_WIDTH-1:0] push_keep;
  logic                  push_last;
  logic                  push_user;
  logic                  skid_ready;

  logic                  beat_last;
  logic                  final_word;
  logic [KEEP_WIDTH-1:0] byte_en;
  logic [DATA_WIDTH-1:0] masked;
  logic                  desc_fire;
  logic                  in_fire;

  assign beat_last  = (bytes_rem <= BEAT_BYTES);
  assign final_word = (words_rem == LEN_WIDTH'(1));
  assign desc_fire  = desc_valid && desc_ready;
  assign in_fire    = in_valid && in_ready;

  always_comb begin
    byte_en = {KEEP_WIDTH{1'b1}};
    masked  = '0;
    // only the final payload word can be partial; a tail of 0 means 8 bytes
    if (final_word) byte_en = keep_from_count({len_tail == 3'd0, len_tail});
    for (int b = 0; b < KEEP_WIDTH; b++)
      masked[8*b +: 8] = byte_en[b] ? in_data[8*b +: 8] : 8'h00;
  end

  always_comb begin
    state_nxt  = state;
    desc_ready = 1'b0;
    in_ready   = 1'b0;
    push_valid = 1'b0;
    push_data  = '0;
    push_keep  = {KEEP_WIDTH{1'b1}};
    push_last  = 1'b0;
    push_user  = 1'b0;
    case (state)
      IDLE: begin
        desc_ready = armed;
        if (desc_valid && armed)
          state_nxt = (desc_len == '0 || desc_len > MAX_LEN) ? DROP : DATA;
      end
      DATA: begin
        in_ready   = skid_ready;
        push_valid = in_valid;
        push_data  = masked;
        push_last  = beat_last;
        push_user  = beat_last && (bad || in_err);
        if (beat_last) push_keep = keep_from_count(bytes_rem[3:0]);
        if (in_valid && skid_ready && final_word)
          state_nxt = beat_last ? IDLE : PAD;
      end
      PAD: begin
        push_valid = 1'b1;
        push_last  = beat_last;
        push_user  = beat_last && bad;
        if (beat_last) push_keep = keep_from_count(bytes_rem[3:0]);
        if (skid_ready && beat_last) state_nxt = IDLE;
      end
      DROP: begin
        in_ready = (words_rem != '0);
        if (words_rem == '0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      armed          <= 1'b0;
      len_tail       <= '0;
      words_rem      <= '0;
      bytes_rem      <= '0;
      bad            <= 1'b0;
      frames_sent    <= '0;
      frames_dropped <= '0;
    end else begin
      state <= state_nxt;
      armed <= 1'b1;
      if (tx_valid && tx_ready && tx_last) frames_sent <= frames_sent + CNT_WIDTH'(1);
      case (state)
        IDLE: begin
          bad <= 1'b0;
          if (desc_fire) begin
            len_tail  <= desc_len[2:0];
            words_rem <= ceil_words(desc_len);
            bytes_rem <= (desc_len < MIN_LEN) ? MIN_LEN : desc_len;
          end
        end
        DATA: if (in_fire) begin
          words_rem <= words_rem - LEN_WIDTH'(1);
          bytes_rem <= bytes_rem - BEAT_BYTES;
          bad       <= bad || in_err;
        end
        PAD: if (skid_ready) bytes_rem <= bytes_rem - BEAT_BYTES;
        DROP: begin
          if (words_rem == '0) frames_dropped <= frames_dropped + CNT_WIDTH'(1);
          else if (in_fire)    words_rem <= words_rem - LEN_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

  accnet_axis_skid #(.W(BW)) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (push_valid),
    .s_data  ({push_user, push_last, push_keep, push_data}),
    .s_ready (skid_ready),
    .m_valid (tx_valid),
    .m_data  ({tx_user, tx_last, tx_keep, tx_data}),
    .m_ready (tx_ready)
  );

endmodule

// File: tb/tb_accnet_tx_framer.sv
module tb_accnet_tx_framer;
  import accnet_tx_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        desc_valid = 1'b0;
  logic [15:0] desc_len = '0;
  logic        desc_ready;
  logic        in_valid = 1'b0;
  logic [63:0] in_data = '0;
  logic        in_err = 1'b0;
  logic        in_ready;
  logic        tx_valid;
  logic [63:0] tx_data;
  logic [7:0]  tx_keep;
  logic        tx_last;
  logic        tx_user;
  logic        tx_ready = 1'b1;
  logic [31:0] frames_sent;
  logic [31:0] frames_dropped;

  always #5 clk = ~clk;

  accnet_tx_framer dut (
    .clk(clk), .rst_n(rst_n),
    .desc_valid(desc_valid), .desc_len(desc_len), .desc_ready(desc_ready),
    .in_valid(in_valid), .in_data(in_data), .in_err(in_err), .in_ready(in_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_keep(tx_keep), .tx_last(tx_last),
    .tx_user(tx_user), .tx_ready(tx_ready),
    .frames_sent(frames_sent), .frames_dropped(frames_dropped)
  );

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic        user;
  } beat_t;

  beat_t exp_q[$];
  int    chk_cnt = 0;
  int    pass_cnt = 0;
  int    beats_seen = 0;
  int    exp_sent = 0;
  int    exp_dropped = 0;
  bit    rand_rdy = 1'b0;
  bit    held = 1'b0;
  beat_t hold_b;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    assert (got === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  // tx monitor: beat order/content against the model, and AXI hold rules
  always @(negedge clk) begin
    beat_t e;
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      if (held) begin
        chk("stall_valid", 64'(tx_valid), 64'd1);
        chk("stall_data", tx_data, hold_b.data);
        chk("stall_side", 64'({tx_keep, tx_last, tx_user}),
            64'({hold_b.keep, hold_b.last, hold_b.user}));
      end
      held   = tx_valid && !tx_ready;
      hold_b = {tx_data, tx_keep, tx_last, tx_user};
      if (tx_valid && tx_ready) begin
        beats_seen++;
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", tx_data, e.data);
          chk("beat_keep", 64'(tx_keep), 64'(e.keep));
          chk("beat_last", 64'(tx_last), 64'(e.last));
          chk("beat_user", 64'(tx_user), 64'(e.user));
        end
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_rdy) tx_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // Reference: frame = L payload bytes (bytes past L zeroed), zero-padded to
  // max(L,60), split into 8-byte beats; keep marks the bytes present.
  task automatic send_frame(input int len, input int err_word, input bit wait_done);
    int          nw, olen, nb, t;
    bit          drop, any_err;
    logic [63:0] words[$];
    logic [7:0]  bytes[$];
    logic [63:0] wd;
    beat_t       b;
    nw   = (len + 7) / 8;
    drop = (len == 0) || (len > MAX_FRAME_BYTES);
    for (int w = 0; w < nw; w++) words.push_back({$urandom, $urandom});
    if (!drop) begin
      any_err = (err_word >= 0) && (err_word < nw);
      for (int i = 0; i < len; i++) begin
        wd = words[i / 8];
        bytes.push_back(wd[8*(i % 8) +: 8]);
      end
      olen = (len < MIN_FRAME_BYTES) ? MIN_FRAME_BYTES : len;
      while (bytes.size() < olen) bytes.push_back(8'h00);
      nb = (olen + 7) / 8;
      for (int k = 0; k < nb; k++) begin
        b = '0;
        for (int j = 0; j < 8; j++)
          if (k * 8 + j < olen) begin
            b.data[8*j +: 8] = bytes[k * 8 + j];
            b.keep[j] = 1'b1;
          end
        b.last = (k == nb - 1);
        b.user = b.last && any_err;
        exp_q.push_back(b);
      end
      exp_sent++;
    end else begin
      exp_dropped++;
    end

    desc_len   = 16'(len);
    desc_valid = 1'b1;
    t = 0;
    while (!desc_ready && t < 2000) begin @(posedge clk); #1; t++; end
    if (t >= 2000) chk("desc_timeout", 64'd1, 64'd0);
    @(posedge clk); #1;
    desc_valid = 1'b0;

    for (int w = 0; w < nw; w++) begin
      in_valid = 1'b1;
      in_data  = words[w];
      in_err   = (w == err_word);
      t = 0;
      while (!in_ready && t < 2000) begin @(posedge clk); #1; t++; end
      if (t >= 2000) chk("word_timeout", 64'd1, 64'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_err   = 1'b0;

    if (wait_done) begin
      t = 0;
      while ((exp_q.size() != 0 || !desc_ready) && t < 5000) begin @(posedge clk); #1; t++; end
      if (t >= 5000) chk("drain_timeout", 64'd1, 64'd0);
      chk("frames_sent", 64'(frames_sent), 64'(exp_sent));
      chk("frames_dropped", 64'(frames_dropped), 64'(exp_dropped));
    end
  endtask

  initial begin
    int t, base, len, nw, errw;

    // reset state
    #1;
    chk("rst_tx_valid", 64'(tx_valid), 64'd0);
    chk("rst_desc_ready", 64'(desc_ready), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_tx_side", 64'({tx_data, tx_keep, tx_last, tx_user} != '0), 64'd0);
    chk("rst_counters", 64'({frames_sent, frames_dropped}), 64'd0);
    #20;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // payload offered while idle must not be taken
    in_valid = 1'b1;
    in_data  = 64'hDEAD_BEEF_0123_4567;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("idle_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;

    // directed lengths with tx_ready held high
    send_frame(128, -1, 1'b1);
    send_frame(13, -1, 1'b1);
    send_frame(61, -1, 1'b1);
    send_frame(0, -1, 1'b1);
    send_frame(9601, -1, 1'b1);
    send_frame(64, -1, 1'b1);
    send_frame(57, -1, 1'b1);
    send_frame(9600, 1199, 1'b1);

    // backpressure with an errored word, then random frames
    rand_rdy = 1'b1;
    send_frame(64, 3, 1'b1);
    for (int f = 0; f < 8; f++) begin
      len  = $urandom_range(1, 200);
      nw   = (len + 7) / 8;
      errw = ($urandom_range(0, 2) == 0) ? $urandom_range(0, nw - 1) : -1;
      send_frame(len, errw, 1'b1);
    end
    rand_rdy = 1'b0;
    #1;
    tx_ready = 1'b1;
    @(posedge clk); #1;

    // reset while padding an L=20 frame
    base = beats_seen;
    send_frame(20, -1, 1'b0);
    t = 0;
    while (beats_seen < base + 4 && t < 200) begin @(posedge clk); #1; t++; end
    if (t >= 200) chk("pad_reach_timeout", 64'd1, 64'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst_tx_valid", 64'(tx_valid), 64'd0);
    chk("midrst_tx_side", 64'({tx_data, tx_keep, tx_last, tx_user} != '0), 64'd0);
    chk("midrst_ready", 64'({desc_ready, in_ready}), 64'd0);
    chk("midrst_counters", 64'({frames_sent, frames_dropped}), 64'd0);
    exp_q.delete();
    exp_sent    = 0;
    exp_dropped = 0;
    #20;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_frame(64, -1, 1'b1);
    chk("post_rst_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
